// File: rtl/ccx_ic_xbar_router.sv
// Core-complex request router: one core port decoded onto NT memory targets with
// in-order response return, an internal error responder for unmapped addresses and stray-response detection.
module ccx_ic_xbar_router #(
    parameter int unsigned AW      = 39,
    parameter int unsigned DW      = 64,
    parameter int unsigned NT      = 3,
    parameter int unsigned MAX_OUT = 4,
    parameter logic [NT*AW-1:0] T_BASE = {39'h00_1000_0000, 39'h00_0001_0000, 39'h00_0000_0000},
    parameter logic [NT*AW-1:0] T_MASK = {39'h7F_F000_0000, 39'h7F_FFFF_0000, 39'h7F_FFFF_FC00}
) (
    input  logic             g_clk,
    input  logic             g_reset,
    input  logic             c_req,
    output logic             c_gnt,
    input  logic [AW-1:0]    c_addr,
    input  logic             c_wen,
    input  logic [DW/8-1:0]  c_strb,
    input  logic [DW-1:0]    c_wdata,
    output logic             c_rsp_valid,
    output logic [DW-1:0]    c_rdata,
    output logic             c_err,
    output logic [NT-1:0]    t_req,
    input  logic [NT-1:0]    t_gnt,
    output logic [AW-1:0]    t_addr,
    output logic             t_wen,
    output logic [DW/8-1:0]  t_strb,
    output logic [DW-1:0]    t_wdata,
    input  logic [NT-1:0]    t_rsp_valid,
    input  logic [NT*DW-1:0] t_rdata,
    input  logic [NT-1:0]    t_err,
    output logic             protocol_err
);

    localparam int unsigned SW = $clog2(NT + 1);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam logic [SW-1:0] NONE = SW'(NT);

    logic [CW-1:0] cnt;
    logic [SW-1:0] last;
    logic          err_pend;

    logic [SW-1:0] sel;
    logic          allow;
    logic          tgt_gnt;
    logic          tgt_rsp;
    logic [DW-1:0] tgt_rdata;
    logic          tgt_err;
    logic          stray;

    assign t_addr  = c_addr;
    assign t_wen   = c_wen;
    assign t_strb  = c_strb;
    assign t_wdata = c_wdata;

    // Address decode: lowest-indexed matching target wins.
    always_comb begin
        sel = NONE;
        for (int i = int'(NT) - 1; i >= 0; i--) begin
            if ((c_addr & T_MASK[i*AW +: AW]) == T_BASE[i*AW +: AW]) sel = SW'(i);
        end
    end

    // Per-target muxes for the request grant (by sel) and response (by last).
    always_comb begin
        tgt_gnt   = 1'b0;
        tgt_rsp   = 1'b0;
        tgt_rdata = '0;
        tgt_err   = 1'b0;
        stray     = 1'b0;
        for (int i = 0; i < int'(NT); i++) begin
            if (sel == SW'(i)) tgt_gnt = t_gnt[i];
            if (last == SW'(i)) begin
                tgt_rsp   = t_rsp_valid[i];
                tgt_rdata = t_rdata[i*DW +: DW];
                tgt_err   = t_err[i];
            end
            if (t_rsp_valid[i] && (cnt == '0 || last != SW'(i))) stray = 1'b1;
        end
    end

    // Only the target already in flight may take more requests, keeping responses ordered.
    assign allow = (cnt == '0) || ((sel == last) && (cnt < CW'(MAX_OUT)));

    always_comb begin
        t_req       = '0;
        c_gnt       = 1'b0;
        c_rsp_valid = 1'b0;
        c_rdata     = '0;
        c_err       = 1'b0;
        if (!g_reset) begin
            for (int i = 0; i < int'(NT); i++) begin
                t_req[i] = c_req && allow && (sel == SW'(i));
            end
            c_gnt       = c_req && allow && ((sel == NONE) ? 1'b1 : tgt_gnt);
            c_rsp_valid = (cnt != '0) && ((last == NONE) ? err_pend : tgt_rsp);
            if (c_rsp_valid) begin
                c_rdata = (last == NONE) ? '0 : tgt_rdata;
                c_err   = (last == NONE) ? 1'b1 : tgt_err;
            end
        end
    end

    // Outstanding-transaction bookkeeping.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cnt          <= '0;
            last         <= NONE;
            err_pend     <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (c_gnt && !c_rsp_valid) begin
                cnt <= cnt + CW'(1);
            end else if (!c_gnt && c_rsp_valid) begin
                cnt <= cnt - CW'(1);
            end
            if (c_gnt) last <= sel;
            err_pend <= c_gnt && (sel == NONE);
            if (stray) protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ccx_ic_xbar_router.sv
// Directed bench for ccx_ic_xbar_router: a per-cycle vector table plus hand-written
// sequences for same-cycle grant/retire and reset while transactions are outstanding.
module tb_ccx_ic_xbar_router;

    logic           g_clk = 1'b0;
    logic           g_reset;
    logic           c_req;
    logic           c_gnt;
    logic [38:0]    c_addr;
    logic           c_wen;
    logic [7:0]     c_strb;
    logic [63:0]    c_wdata;
    logic           c_rsp_valid;
    logic [63:0]    c_rdata;
    logic           c_err;
    logic [2:0]     t_req;
    logic [2:0]     t_gnt;
    logic [38:0]    t_addr;
    logic           t_wen;
    logic [7:0]     t_strb;
    logic [63:0]    t_wdata;
    logic [2:0]     t_rsp_valid;
    logic [191:0]   t_rdata;
    logic [2:0]     t_err;
    logic           protocol_err;

    int checks = 0;
    int errors = 0;

    ccx_ic_xbar_router dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .c_req(c_req), .c_gnt(c_gnt), .c_addr(c_addr), .c_wen(c_wen),
        .c_strb(c_strb), .c_wdata(c_wdata),
        .c_rsp_valid(c_rsp_valid), .c_rdata(c_rdata), .c_err(c_err),
        .t_req(t_req), .t_gnt(t_gnt), .t_addr(t_addr), .t_wen(t_wen),
        .t_strb(t_strb), .t_wdata(t_wdata),
        .t_rsp_valid(t_rsp_valid), .t_rdata(t_rdata), .t_err(t_err),
        .protocol_err(protocol_err)
    );

    always #5 g_clk = ~g_clk;

    typedef struct {
        string       name;
        logic        req;
        logic [38:0] addr;
        logic [2:0]  gnt;
        logic [2:0]  rsp;
        logic [2:0]  terr;
        logic [2:0]  x_treq;
        logic        x_gnt;
        logic        x_rsp;
        logic [63:0] x_rdata;
        logic        x_err;
        logic [2:0]  x_cnt;
        logic        x_perr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [63:0] RD0 = 64'h0000_0000_0000_DEAD;
    localparam logic [63:0] RD1 = 64'h0000_0000_BEEF_0001;
    localparam logic [63:0] RD2 = 64'h0000_0000_CAFE_0002;
    localparam logic [38:0] UNM = 39'h00_0800_0000;

    function automatic vec_t mk(string n, logic rq, logic [38:0] a, logic [2:0] g,
                                logic [2:0] r, logic [2:0] te, logic [2:0] xtr,
                                logic xg, logic xr, logic [63:0] xd, logic xe,
                                logic [2:0] xc, logic xp);
        vec_t v;
        v.name = n; v.req = rq; v.addr = a; v.gnt = g; v.rsp = r; v.terr = te;
        v.x_treq = xtr; v.x_gnt = xg; v.x_rsp = xr; v.x_rdata = xd; v.x_err = xe;
        v.x_cnt = xc; v.x_perr = xp;
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic rq, logic [38:0] a, logic [2:0] g, logic [2:0] r, logic [2:0] te);
        c_req = rq; c_addr = a; t_gnt = g; t_rsp_valid = r; t_err = te;
    endtask

    task automatic next_cycle();
        @(negedge g_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        g_reset = 1'b1;
        c_wen = 1'b0; c_strb = 8'hFF; c_wdata = 64'h1234_5678_9ABC_DEF0;
        t_rdata = {RD2, RD1, RD0};
        drive(1'b1, 39'h100, 3'b111, 3'b000, 3'b000);

        // cycle table: inputs, then outputs/state observed in the same cycle before the edge
        vecs.push_back(mk("rom_req",    1, 39'h100,     3'b001, 3'b000, 3'b000, 3'b001, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("rom_rsp",    0, 39'h100,     3'b000, 3'b001, 3'b000, 3'b000, 0, 1, RD0, 0, 1, 0));
        vecs.push_back(mk("rom_idle",   0, 39'h100,     3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("ram_rd0",    1, 39'h1_0000,  3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("ram_rd1",    1, 39'h1_0008,  3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0,   0, 1, 0));
        vecs.push_back(mk("ram_rd2",    1, 39'h1_0010,  3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0,   0, 2, 0));
        vecs.push_back(mk("ram_rd3",    1, 39'h1_0018,  3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0,   0, 3, 0));
        vecs.push_back(mk("ram_full",   1, 39'h1_0020,  3'b010, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 4, 0));
        vecs.push_back(mk("ram_full_r", 1, 39'h1_0020,  3'b010, 3'b010, 3'b000, 3'b000, 0, 1, RD1, 0, 4, 0));
        vecs.push_back(mk("ram_rd4",    1, 39'h1_0020,  3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0,   0, 3, 0));
        vecs.push_back(mk("ram_drain4", 0, 39'h1_0020,  3'b000, 3'b010, 3'b000, 3'b000, 0, 1, RD1, 0, 4, 0));
        vecs.push_back(mk("ram_drain3", 0, 39'h1_0020,  3'b000, 3'b010, 3'b000, 3'b000, 0, 1, RD1, 0, 3, 0));
        vecs.push_back(mk("ram_drain2", 0, 39'h1_0020,  3'b000, 3'b010, 3'b000, 3'b000, 0, 1, RD1, 0, 2, 0));
        vecs.push_back(mk("ram_drain1", 0, 39'h1_0020,  3'b000, 3'b010, 3'b000, 3'b000, 0, 1, RD1, 0, 1, 0));
        vecs.push_back(mk("ram_empty",  0, 39'h1_0020,  3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("sw_ram",     1, 39'h1_0000,  3'b010, 3'b000, 3'b000, 3'b010, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("sw_ext_blk", 1, 39'h1000_0000, 3'b100, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk("sw_ext_ret", 1, 39'h1000_0000, 3'b100, 3'b010, 3'b000, 3'b000, 0, 1, RD1, 0, 1, 0));
        vecs.push_back(mk("sw_ext_go",  1, 39'h1000_0000, 3'b100, 3'b000, 3'b000, 3'b100, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("ext_err",    0, 39'h1000_0000, 3'b000, 3'b100, 3'b100, 3'b000, 0, 1, RD2, 1, 1, 0));
        vecs.push_back(mk("ext_idle",   0, 39'h1000_0000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("unm_req",    1, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("unm_rsp",    0, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0,   1, 1, 0));
        vecs.push_back(mk("unm_idle",   0, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("b2b_unm0",   1, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("b2b_unm1",   1, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 1, 1, 0,   1, 1, 0));
        vecs.push_back(mk("b2b_rsp",    0, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0,   1, 1, 0));
        vecs.push_back(mk("b2b_idle",   0, UNM,         3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("rom_nognt",  1, 39'h100,     3'b000, 3'b000, 3'b000, 3'b001, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("rom_top",    1, 39'h3F8,     3'b001, 3'b000, 3'b000, 3'b001, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("rom_top_r",  0, 39'h3F8,     3'b000, 3'b001, 3'b000, 3'b000, 0, 1, RD0, 0, 1, 0));
        vecs.push_back(mk("rom_top_i",  0, 39'h3F8,     3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("rom_past",   1, 39'h400,     3'b111, 3'b000, 3'b000, 3'b000, 1, 0, 0,   0, 0, 0));
        vecs.push_back(mk("rom_past_r", 0, 39'h400,     3'b000, 3'b000, 3'b000, 3'b000, 0, 1, 0,   1, 1, 0));
        vecs.push_back(mk("rom_past_i", 0, 39'h400,     3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("stray",      0, 39'h400,     3'b000, 3'b100, 3'b000, 3'b000, 0, 0, 0,   0, 0, 0));
        vecs.push_back(mk("stray_seen", 0, 39'h400,     3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0,   0, 0, 1));

        // reset: outputs held low even with an active request
        next_cycle();
        #1;
        chk("rst_t_req", 64'(t_req), 64'(3'b000));
        chk("rst_c_gnt", 64'(c_gnt), 64'(1'b0));
        next_cycle();
        g_reset = 1'b0;
        drive(1'b0, 39'h0, 3'b000, 3'b000, 3'b000);
        #1;
        chk("rst_cnt",  64'(dut.cnt), 64'(3'd0));
        chk("rst_perr", 64'(protocol_err), 64'(1'b0));
        chk("rst_rsp",  64'(c_rsp_valid), 64'(1'b0));

        foreach (vecs[k]) begin
            next_cycle();
            drive(vecs[k].req, vecs[k].addr, vecs[k].gnt, vecs[k].rsp, vecs[k].terr);
            #1;
            chk({vecs[k].name, ".t_req"},  64'(t_req),        64'(vecs[k].x_treq));
            chk({vecs[k].name, ".c_gnt"},  64'(c_gnt),        64'(vecs[k].x_gnt));
            chk({vecs[k].name, ".rsp"},    64'(c_rsp_valid),  64'(vecs[k].x_rsp));
            chk({vecs[k].name, ".rdata"},  c_rdata,           vecs[k].x_rdata);
            chk({vecs[k].name, ".err"},    64'(c_err),        64'(vecs[k].x_err));
            chk({vecs[k].name, ".cnt"},    64'(dut.cnt),      64'(vecs[k].x_cnt));
            chk({vecs[k].name, ".perr"},   64'(protocol_err), 64'(vecs[k].x_perr));
        end
        chk("bcast_addr",  64'(t_addr),  64'(39'h400));
        chk("bcast_wdata", t_wdata,      64'h1234_5678_9ABC_DEF0);

        // sticky protocol_err cleared by reset
        next_cycle();
        g_reset = 1'b1;
        drive(1'b0, 39'h0, 3'b000, 3'b000, 3'b000);
        next_cycle();
        g_reset = 1'b0;
        #1;
        chk("perr_clr", 64'(protocol_err), 64'(1'b0));

        // same-cycle grant and retirement with cnt=2
        for (int n = 0; n < 2; n++) begin
            next_cycle();
            drive(1'b1, 39'h1_0000, 3'b010, 3'b000, 3'b000);
            #1;
            chk("fill_gnt", 64'(c_gnt), 64'(1'b1));
        end
        next_cycle();
        drive(1'b1, 39'h1_0010, 3'b010, 3'b010, 3'b000);
        #1;
        chk("both_gnt", 64'(c_gnt), 64'(1'b1));
        chk("both_rsp", 64'(c_rsp_valid), 64'(1'b1));
        chk("both_cnt_pre", 64'(dut.cnt), 64'(3'd2));
        next_cycle();
        drive(1'b1, 39'h1_0018, 3'b010, 3'b000, 3'b000);
        #1;
        chk("both_cnt_post", 64'(dut.cnt), 64'(3'd2));

        // reset with three outstanding; a late target response is then stray
        next_cycle();
        #1;
        chk("cnt3", 64'(dut.cnt), 64'(3'd3));
        g_reset = 1'b1;
        drive(1'b1, 39'h1_0020, 3'b010, 3'b010, 3'b010);
        #1;
        chk("mid_rst_gnt",   64'(c_gnt), 64'(1'b0));
        chk("mid_rst_treq",  64'(t_req), 64'(3'b000));
        chk("mid_rst_rsp",   64'(c_rsp_valid), 64'(1'b0));
        chk("mid_rst_rdata", c_rdata, 64'h0);
        chk("mid_rst_err",   64'(c_err), 64'(1'b0));
        next_cycle();
        g_reset = 1'b0;
        drive(1'b0, 39'h0, 3'b000, 3'b010, 3'b000);
        #1;
        chk("post_rst_cnt", 64'(dut.cnt), 64'(3'd0));
        chk("post_rst_rsp", 64'(c_rsp_valid), 64'(1'b0));
        next_cycle();
        drive(1'b0, 39'h0, 3'b000, 3'b000, 3'b000);
        #1;
        chk("late_stray_perr", 64'(protocol_err), 64'(1'b1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
